lc3_bus_gate_ctrl: RTL
======================

// Module: lc3_bus_gate_ctrl
// PURPOSE
//  Upstream controller for the tristate_b bus drivers on the LC-3 16-bit system bus.
//  Turns gate requests from the control FSM (GatePC, GateMDR, GateALU, GateMARMUX) into
//  registered one-hot SEL enables, one per tristate_b instance.
//  Enforces break-before-make turnaround between drivers, flags multi-driver requests,
//  and presents a registered copy of the driven bus word.
// PARAMETERS
//  NUM_SRC   4   number of bus sources / tristate_b instances (>=2)
//  WIDTH     16  bus width in bits
//  TURN_CYC  1   idle cycles with all SEL low between two different drivers (>=1)
// PORTS
//  CLK        in   1              rising-edge clock
//  RST_N      in   1              asynchronous reset, active low
//  GATE_REQ   in   NUM_SRC        per-source gate request from control FSM; bit0 = highest priority
//  SRC_DATA   in   NUM_SRC*WIDTH  source words; source i at [i*WIDTH +: WIDTH]
//  CLR_ERR    in   1              clears CONTENTION
//  SEL        out  NUM_SRC        one-hot (or zero) enables to the tristate_b SEL inputs
//  GRANT_IDX  out  $clog2(NUM_SRC) index of current/last driver
//  BUS_VALID  out  1              high while a driver is enabled (state DRIVE)
//  BUS_DATA   out  WIDTH          registered bus word
//  CONTENTION out  1              sticky: >1 GATE_REQ bits seen high in one cycle
// BEHAVIOUR
//  - Reset (RST_N=0, async): state IDLE, SEL=0, GRANT_IDX=0, BUS_VALID=0, BUS_DATA=0,
//    CONTENTION=0, turnaround counter=0. Reset asserted mid-DRIVE drops SEL at once, no clock needed.
//  - All outputs are registered. SEL is never more than one-hot, in any cycle.
//  - Winner = lowest-index set bit of GATE_REQ.
//  - FSM states IDLE, DRIVE, TURN:
//    IDLE : any GATE_REQ bit set -> DRIVE; SEL=onehot(winner) and GRANT_IDX=winner on the
//           next edge (1-cycle request-to-SEL latency). No request -> stay IDLE.
//    DRIVE: GATE_REQ[GRANT_IDX]=1 -> stay; no preemption by higher-priority requests.
//           GATE_REQ[GRANT_IDX]=0 -> SEL=0, load counter with TURN_CYC, go TURN.
//    TURN : SEL=0; counter decrements each cycle. Counter reaches 0 with a request pending
//           -> DRIVE the winner sampled that cycle. Counter reaches 0 with no request -> IDLE.
//  - Re-requesting the same source after release still takes the full TURN.
//  - BUS_VALID=1 exactly when state==DRIVE (same cycle as SEL).
//  - BUS_DATA <= SRC_DATA[GRANT_IDX] on every edge where the next state is DRIVE with the
//    same GRANT_IDX as the current one, i.e. it lags SEL by one cycle.
//  - CONTENTION: set on any edge where popcount(GATE_REQ)>1. Cleared by CLR_ERR=1.
//    Set and clear in the same cycle -> stays set.
//  - GRANT_IDX holds its last value in IDLE and TURN.
// CONFIGURATION
//  BUS_KEEPER_EN defined  : BUS_DATA holds the last driven word through TURN and IDLE
//                           (models a bus keeper).
//  BUS_KEEPER_EN undefined: BUS_DATA is cleared to 0 on the first edge after leaving DRIVE
//                           and stays 0 until the next DRIVE capture.
// TESTING
//  1 Reset: RST_N=0 mid-DRIVE -> SEL=0000, BUS_VALID=0, CONTENTION=0 with no clock edge.
//  2 Single grant: GATE_REQ=0100, SRC_DATA[2]=16'h3A5C -> next edge SEL=0100, GRANT_IDX=2;
//    one edge later BUS_DATA=16'h3A5C.
//  3 Handover, TURN_CYC=1: hold GATE_REQ=0001 then switch to 0010 -> SEL 0001, 0000 for
//    exactly 1 cycle, then 0010; never two bits high.
//  4 No preemption: in DRIVE on src 3, raise GATE_REQ=1001 -> SEL stays 1000 and
//    CONTENTION=1. Same cycle CLR_ERR=1 -> CONTENTION still 1; CLR_ERR alone next -> 0.
//  5 Release to idle: drop all requests from DRIVE src 1 (data 16'hBEEF) -> TURN, then IDLE.
//    BUS_DATA=16'hBEEF with BUS_KEEPER_EN, 16'h0000 without it.
//  6 Priority from IDLE: GATE_REQ=1110 in one cycle -> SEL=0010 and CONTENTION=1.

Source files
------------

// File: rtl/lc3_bus_gate_ctrl.sv
// Bus gate controller for the LC-3 tristate_b drivers: priority grant, break-before-make
// turnaround, contention flag and a registered bus word. Optional macro: BUS_KEEPER_EN.
module lc3_bus_gate_ctrl #(
    parameter int unsigned NUM_SRC  = 4,
    parameter int unsigned WIDTH    = 16,
    parameter int unsigned TURN_CYC = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_SRC-1:0]         gate_req,
    input  logic [NUM_SRC*WIDTH-1:0]   src_data,
    input  logic                       clr_err,
    output logic [NUM_SRC-1:0]         sel,
    output logic [$clog2(NUM_SRC)-1:0] grant_idx,
    output logic                       bus_valid,
    output logic [WIDTH-1:0]           bus_data,
    output logic                       contention
);

    localparam int unsigned IdxW = $clog2(NUM_SRC);
    localparam int unsigned CntW = $clog2(TURN_CYC + 1);

    typedef enum logic [1:0] {StIdle, StDrive, StTurn} state_e;

    state_e            state_q, state_d;
    logic [IdxW-1:0]   grant_q, grant_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [NUM_SRC-1:0] sel_q, sel_d;
    logic              valid_q;
    logic [WIDTH-1:0]  data_q, data_d;
    logic              cont_q, cont_d;
    logic [IdxW-1:0]   winner;
    logic              any_req;
    logic              capture;

    // Scan downward so the lowest-index request wins.
    always_comb begin
        any_req = |gate_req;
        winner  = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (gate_req[i]) winner = IdxW'(i);
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (any_req) begin
                    state_d = StDrive;
                    grant_d = winner;
                end
            end
            StDrive: begin
                // Owner keeps the bus until it drops its own request; no preemption.
                if (!gate_req[grant_q]) begin
                    state_d = StTurn;
                    cnt_d   = CntW'(TURN_CYC);
                end
            end
            StTurn: begin
                cnt_d = cnt_q - CntW'(1);
                if (cnt_q <= CntW'(1)) begin
                    cnt_d = '0;
                    if (any_req) begin
                        state_d = StDrive;
                        grant_d = winner;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        sel_d = '0;
        if (state_d == StDrive) sel_d[grant_d] = 1'b1;
    end

    // Word is captured only while the same driver stays enabled, so it lags sel by a cycle.
    assign capture = (state_q == StDrive) && (state_d == StDrive);

    always_comb begin
        if (capture) begin
            data_d = src_data[grant_q*WIDTH +: WIDTH];
        end else begin
`ifdef BUS_KEEPER_EN
            data_d = data_q;
`else
            data_d = '0;
`endif
        end
    end

    // A new contention event beats a simultaneous clear.
    always_comb begin
        cont_d = cont_q;
        if ($countones(gate_req) > 1) cont_d = 1'b1;
        else if (clr_err)             cont_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            grant_q <= '0;
            cnt_q   <= '0;
            sel_q   <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            cont_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            valid_q <= (state_d == StDrive);
            data_q  <= data_d;
            cont_q  <= cont_d;
        end
    end

    assign sel        = sel_q;
    assign grant_idx  = grant_q;
    assign bus_valid  = valid_q;
    assign bus_data   = data_q;
    assign contention = cont_q;

endmodule
